// File: rtl/ordenador4_ctrl_if.sv
// Handshake bundle for the 4-entry sorter: input stream, output stream
// and the busy flag. The slave modport is the sorter's view.
interface ordenador4_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ordenador4_ctrl.sv
// Four-entry, 8-bit ascending sorter. Loads four values, runs a fixed
// six-step bubble network through a single shared comparator, then streams
// the sorted values out with a last marker on the largest one.

// Unsigned less-than comparator shared by every sort step.
module comparador8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       s
);
  assign s = (a < b);
endmodule

module ordenador4_ctrl (
  input  logic                clk,
  input  logic                rst,
  ordenador4_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [1:0] rcnt_q, rcnt_d;
  logic [2:0] step_q, step_d;
  logic [7:0] r_q [4];
  logic [7:0] r_d [4];

  logic [1:0] pairLo;
  logic [1:0] pairHi;
  logic [7:0] cmpA;
  logic [7:0] cmpB;
  logic       cmpLess;
  logic       inReady;
  logic       outValid;

  // Map the sort step to the lower index of the pair it compares; the
  // sequence 0,1,2,0,1,0 is a complete bubble sort of four entries.
  always_comb begin
    pairLo = 2'd0;
    case (step_q)
      3'd0, 3'd3, 3'd5: pairLo = 2'd0;
      3'd1, 3'd4:       pairLo = 2'd1;
      3'd2:             pairLo = 2'd2;
      default:          pairLo = 2'd0;
    endcase
    pairHi = pairLo + 2'd1;
    cmpA   = r_q[pairHi];
    cmpB   = r_q[pairLo];
  end

  comparador8b u_cmp (
    .a (cmpA),
    .b (cmpB),
    .s (cmpLess)
  );

  // Handshake flags come only from registered state; reset forces both low
  // so nothing is offered or accepted while the block is being cleared.
  assign inReady       = (state_q == LOAD) && !rst;
  assign outValid      = (state_q == OUT)  && !rst;
  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = r_q[rcnt_q];
  assign bus.out_last  = (state_q == OUT) && (rcnt_q == 2'd3);
  assign bus.busy      = (state_q != LOAD);

  // Next-state logic: load counter, sort network step, output counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    step_d  = step_q;
    for (int i = 0; i < 4; i++) begin
      r_d[i] = r_q[i];
    end

    case (state_q)
      LOAD: begin
        if (bus.in_valid && inReady) begin
          r_d[wcnt_q] = bus.in_data;
          wcnt_d      = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d = SORT;
          end
        end
      end
      SORT: begin
        // Strictly-less swap keeps equal values in place.
        if (cmpLess) begin
          r_d[pairLo] = r_q[pairHi];
          r_d[pairHi] = r_q[pairLo];
        end
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = OUT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      OUT: begin
        if (outValid && bus.out_ready) begin
          rcnt_d = rcnt_q + 2'd1;
          if (rcnt_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wcnt_q  <= 2'd0;
      rcnt_q  <= 2'd0;
      step_q  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      step_q  <= step_d;
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

endmodule

// File: doc/ordenador4_ctrl.md
ORDENADOR4_CTRL -- requirements
Module: ordenador4_ctrl

Interface
Parameters: none; block size fixed at 4 entries of 8 bits.
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port in_valid  input  1  producer presents in_data.
REQ-004 SHALL have port in_data  input  8  unsigned value to load.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port out_valid  output  1  out_data holds a sorted entry.
REQ-007 SHALL have port out_data  output  8  sorted value, ascending order.
REQ-008 SHALL have port out_last  output  1  marks the 4th (largest) output entry.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port busy  output  1  high when the state is not LOAD.

Function
REQ-011 SHALL hold 4 x 8-bit entry registers r0..r3 and use exactly one comparador8b instance (s = 1 iff a < b, unsigned) for all ordering decisions.
REQ-012 SHALL implement FSM states LOAD, SORT, OUT; no other reachable states.
REQ-013 LOAD: in_ready = 1; on in_valid & in_ready, write in_data to r[wcnt] and increment wcnt (2-bit).
REQ-014 LOAD -> SORT on the edge that accepts the 4th entry (wcnt = 3); wcnt wraps to 0.
REQ-015 SORT: in_ready = 0, out_valid = 0; in_valid and in_data ignored.
REQ-016 SORT SHALL run exactly 6 steps, one per cycle, indexed by step (3-bit, 0..5); pair compared per step: (r0,r1), (r1,r2), (r2,r3), (r0,r1), (r1,r2), (r0,r1).
REQ-017 Each step for pair (rj,rj+1): comparator a = rj+1, b = rj; if s = 1, swap rj and rj+1 at the clock edge; if s = 0, including equality, no swap (stable).
REQ-018 SORT -> OUT on the edge completing step 5; step returns to 0.
REQ-019 Latency: when the 4th entry is accepted at edge E0, out_valid SHALL first be high in the cycle following edge E0+6.
REQ-020 OUT: out_valid = 1, out_data = r[rcnt], out_last = (rcnt = 3); rcnt (2-bit) increments on out_valid & out_ready.
REQ-021 While out_valid = 1 and out_ready = 0, out_data, out_last and rcnt SHALL stay stable.
REQ-022 OUT -> LOAD on the edge accepting the entry with out_last = 1; rcnt wraps to 0; in_ready is high in the next cycle.
REQ-023 in_ready and out_valid SHALL never both be 1 in the same cycle.
REQ-024 Outputs SHALL be decoded from registered state and counters only; out_valid, out_data and out_last SHALL NOT depend combinationally on out_ready or in_valid.
REQ-025 The block SHALL NOT stall in SORT; SORT always takes 6 cycles regardless of data.

Reset
REQ-026 When rst = 1 at a rising edge: state = LOAD, wcnt = step = rcnt = 0, r0..r3 = 8'h00.
REQ-027 While rst = 1, in_ready SHALL be 0 and out_valid SHALL be 0; in the first cycle after rst is deasserted, in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_data = 8'h00.
REQ-028 rst SHALL take priority over all other events in any state, including mid-LOAD, mid-SORT and mid-OUT; partial data is discarded and no further output entries are produced.

Verification
REQ-029 Load 40,30,20,10 with no backpressure -> outputs 10,20,30,40; out_last only on 40; first out_valid 6 cycles after the 4th accept edge (REQ-019).
REQ-030 Load 5,255,0,5 -> outputs 0,5,5,255; duplicates are preserved and the ordering is unsigned (255 is largest).
REQ-031 Load already-sorted 1,2,3,4 -> still exactly 6 SORT cycles; outputs 1,2,3,4.
REQ-032 Hold out_ready = 0 for 3 cycles on each output entry -> out_data and out_last stable throughout; the full sequence is correct; in_ready returns high only after the last handshake.
REQ-033 Hold in_valid = 1 with changing in_data during SORT and OUT -> no data captured; the next frame loads cleanly afterwards.
REQ-034 Assert rst for 1 cycle at SORT step 3, then load 9,8,7,6 -> no stale outputs appear; outputs 6,7,8,9.
